// File: rtl/fast_pixel_ingress_if.sv
// AXI4-Stream pixel beat bundle between the DMA and fast_pixel_ingress.
interface fast_pixel_ingress_if #(
  parameter int unsigned PIXEL_WIDTH = 8
);
  logic [PIXEL_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tuser;
  logic                   tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/fast_pixel_ingress.sv
// Pixel ingress for the FAST 7x7 patch stage: SOF/EOL framing checks, elastic FIFO, resync on error.
// Define FAST_INGRESS_STATS_EN to add the frame_cnt / drop_cnt statistics outputs.
module fast_pixel_ingress #(
  parameter int unsigned COL_NUM     = 640,
  parameter int unsigned ROW_NUM     = 480,
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  fast_pixel_ingress_if.slave    s_axis,
  input  logic                   hold,
  output logic [PIXEL_WIDTH-1:0] pix_data,
  output logic                   pix_ce,
  output logic                   pipe_rst,
  output logic                   frame_done,
  output logic                   err_sof,
  output logic                   err_eol
`ifdef FAST_INGRESS_STATS_EN
  ,
  output logic [15:0]            frame_cnt,
  output logic [15:0]            drop_cnt
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
  localparam int unsigned RW = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COL_NUM - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW_NUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DROP, S_FLUSH} state_t;

  state_t r_state, w_next;

  logic [PIXEL_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]            r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]          r_col;
  logic [RW-1:0]          r_row;
  logic [PIXEL_WIDTH-1:0] r_sof_data;
  logic [PIXEL_WIDTH-1:0] r_pix_data;
  logic                   r_pix_ce, r_frame_done, r_err_sof, r_err_eol;

  logic w_full, w_empty, w_tready, w_acc;
  logic w_col_last, w_row_last, w_framed, w_sof_bad, w_eol_bad;
  logic w_push, w_keep, w_pop, w_frame_end, w_set_sof, w_set_eol, w_pipe_rst;

  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  // DROP discards everything except the next SOF, which FLUSH absorbs, so it never needs FIFO room.
  assign w_tready = !rst && (r_state != S_FLUSH) && ((r_state == S_DROP) || !w_full);
  assign s_axis.tready = w_tready;
  assign w_acc = s_axis.tvalid && w_tready;

  // Col/row are always (0,0) in IDLE, so an IDLE SOF beat is checked exactly like a STREAM beat.
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);
  assign w_framed   = (r_state == S_STREAM) || ((r_state == S_IDLE) && s_axis.tuser);
  assign w_sof_bad  = s_axis.tuser && !((r_col == '0) && (r_row == '0));
  assign w_eol_bad  = (s_axis.tlast != w_col_last);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_STREAM: begin
        if (w_acc && w_framed) begin
          if (w_sof_bad)                     w_next = S_FLUSH;
          else if (w_eol_bad)                w_next = S_DROP;
          else if (w_col_last && w_row_last) w_next = S_IDLE;
          else                               w_next = S_STREAM;
        end
      end
      S_DROP:  if (w_acc && s_axis.tuser) w_next = S_FLUSH;
      S_FLUSH: w_next = S_STREAM;
      default: w_next = S_IDLE;
    endcase
  end

  // Pops stop as soon as an error is decided so no stale pixel reaches the patch stage around pipe_rst.
  always_comb begin
    w_push      = w_acc && w_framed && !w_sof_bad && !w_eol_bad;
    w_keep      = w_acc && ((w_framed && w_sof_bad) || ((r_state == S_DROP) && s_axis.tuser));
    w_set_sof   = w_acc && w_framed && w_sof_bad;
    w_set_eol   = w_acc && w_framed && w_eol_bad;
    w_frame_end = w_push && w_col_last && w_row_last;
    w_pop       = !w_empty && !hold &&
                  ((r_state == S_IDLE) || (r_state == S_STREAM)) &&
                  ((w_next == S_IDLE) || (w_next == S_STREAM));
    w_pipe_rst  = (r_state == S_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (r_state == S_FLUSH) r_mem[0] <= r_sof_data;
    else if (w_push)        r_mem[r_wr_ptr[AW-1:0]] <= s_axis.tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_sof_data   <= '0;
      r_pix_data   <= '0;
      r_pix_ce     <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_sof    <= 1'b0;
      r_err_eol    <= 1'b0;
    end else begin
      r_pix_ce     <= w_pop;
      r_frame_done <= w_frame_end;
      if (w_pop)     r_pix_data <= r_mem[r_rd_ptr[AW-1:0]];
      if (w_keep)    r_sof_data <= s_axis.tdata;
      if (w_set_sof) r_err_sof  <= 1'b1;
      if (w_set_eol) r_err_eol  <= 1'b1;
      if (r_state == S_FLUSH) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= (AW+1)'(1);
        r_col    <= CW'(1);
        r_row    <= '0;
      end else begin
        if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
          if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? '0 : r_row + RW'(1);
          end else begin
            r_col <= r_col + CW'(1);
          end
        end
      end
    end
  end

  assign pix_data   = r_pix_data;
  assign pix_ce     = r_pix_ce;
  assign pipe_rst   = w_pipe_rst;
  assign frame_done = r_frame_done;
  assign err_sof    = r_err_sof;
  assign err_eol    = r_err_eol;

`ifdef FAST_INGRESS_STATS_EN
  logic        w_drop;
  logic [15:0] r_frame_cnt, r_drop_cnt;

  assign w_drop = w_acc && !w_push && !w_keep;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign drop_cnt  = r_drop_cnt;
`endif

endmodule
